alu_issue_stage: RTL and testbench
==================================

Name: alu_issue_stage

Overview:
ID/EX pipeline stage that sits in front of the ALU.
- Accepts decoded-register-read instructions over a valid/ready handshake.
- Decodes opcode/funct3/funct7 into the 3-bit ALU op code and selects operand1/operand2.
- Presents registered operands to the ALU.
- Takes back the ALU zero flag to resolve BEQ/BNE.
- 2-entry skid buffer, so in_ready is a registered signal.

Parameters:
XLEN, 32, datapath width of operands, PC and immediates
OP_W, 3, width of ALU op field

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  synchronous active-low reset
in_valid  input  1  upstream instruction valid
in_ready  output  1  stage can accept; registered, no combinational path from out_ready
in_instr  input  32  RV32 instruction word
in_rs1_val  input  XLEN  rs1 register value
in_rs2_val  input  XLEN  rs2 register value
in_pc  input  XLEN  instruction PC
flush  input  1  kill all held entries (taken branch/redirect)
out_valid  output  1  ALU operands valid
out_ready  input  1  EX stage accepts
out_operand1  output  XLEN  ALU operand1
out_operand2  output  XLEN  ALU operand2
out_alu_op  output  OP_W  ALU op code
out_rd  output  5  destination register
out_reg_write  output  1  result is written back
out_is_branch  output  1  entry is BEQ/BNE
out_branch_ne  output  1  1=BNE, 0=BEQ
out_branch_target  output  XLEN  pc + B-imm
out_illegal  output  1  unsupported encoding; treated as NOP
alu_zero  input  1  ALU zero flag for the entry at the output
branch_taken  output  1  combinational: out_valid & out_is_branch & (alu_zero XOR out_branch_ne)

Behaviour:
- Reset (rst_n=0 at clk edge): both skid entries invalid.
  - out_valid=0; in_ready=1.
  - All out_* data fields = 0; branch_taken=0.
- Op codes: ADD=000, SUB=001, AND=010, OR=011, MUL=100, SLL=101; 110/111 are never emitted.
- Decode of R-type, opcode 0110011, operand1=rs1, operand2=rs2, reg_write=1:
  - f7=0000000: f3 000→ADD, 001→SLL, 110→OR, 111→AND.
  - f7=0100000 with f3 000 → SUB.
  - f7=0000001 with f3 000 → MUL.
- Decode of I-type ALU, opcode 0010011, operand2=sign-extended imm[11:0], reg_write=1:
  - f3 000→ADD, 110→OR, 111→AND.
  - f3 001 with imm[11:5]=0 → SLL, operand2 = zero-extended shamt[4:0].
- Loads (0000011) and stores (0100011): ADD, operand1=rs1, operand2=I-imm or S-imm.
  - reg_write=1 for loads, 0 for stores.
- BEQ/BNE (1100011, f3 000/001): SUB, operand2=rs2, reg_write=0, is_branch=1.
  - target = pc + sign-extended B-imm, mod 2^XLEN.
- Anything else:
  - illegal=1, reg_write=0, is_branch=0, alu_op=ADD, operands 0.
  - Still passes through the handshake.
- Decode is combinational on input; the result is captured into the skid entry on accept (in_valid & in_ready).
- Latency: accepted instruction appears at the output the next cycle when empty. Throughput 1/cycle with out_ready=1.
- Skid buffer:
  - main entry drives outputs; spare entry catches one accept made while out_ready was low.
  - in_ready = spare entry empty (registered).
  - Order preserved; never overwrites a valid entry.
- Output handshake: out_* stable while out_valid & !out_ready.
- Flush: next cycle both entries invalid, out_valid=0, in_ready=1.
  - An accept in the flush cycle is discarded.
  - Flush takes priority over every other event.
- Simultaneous accept and dequeue when main full / spare empty: new instruction replaces main; spare stays empty.
- Reset mid-stream: identical to flush plus clears data fields.

Optional Feature:
ALU_ISSUE_MUL_EN
- Defined: f7=0000001/f3=000 decodes to MUL.
- Undefined: that encoding is illegal (out_illegal=1, reg_write=0); op 100 is never emitted.

Decomposition:
- Shared package alu_pkg: ALU op localparams (ADD..SLL), RV32 opcode constants, funct3/funct7 constants, decoded-bundle struct/width constant.
- One sub-module: alu_issue_decode (pure combinational instr/rs/pc → bundle), instantiated once before the skid buffer.

Test Plan:
- add x3,x1,x2 with rs1=5, rs2=7, out_ready=1 → next cycle out_valid=1, op=000, operands 5/7, rd=3, reg_write=1.
- addi x4,x1,-1 (imm=0xFFF) → operand2=0xFFFFFFFF, op=000; slli x4,x1,3 → op=101, operand2=3.
- beq, rs1=rs2=9, pc=0x100, imm=+16 → op=001, target=0x110; alu_zero=1 → branch_taken=1. Same with bne → 0.
- out_ready=0 with 3 back-to-back in_valid → two accepted, in_ready=0 on the 3rd. Release out_ready → outputs drain in order, no loss/dup.
- flush asserted while 2 entries held plus in_valid → next cycle out_valid=0, in_ready=1, flushed instructions never appear.
- instr 0x0220_81B3 (mul) → op=100 with ALU_ISSUE_MUL_EN, illegal=1 without. Opcode 0x7F → illegal=1, reg_write=0.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg -- shared definitions for the ALU issue stage.
//   ALU op codes, RV32 opcode/funct3/funct7 constants and the decoded
//   bundle carried through the skid buffer.
package alu_pkg;

  localparam int ALU_XLEN = 32;
  localparam int ALU_OP_W = 3;

  localparam logic [ALU_OP_W-1:0] OP_ADD = 3'b000;
  localparam logic [ALU_OP_W-1:0] OP_SUB = 3'b001;
  localparam logic [ALU_OP_W-1:0] OP_AND = 3'b010;
  localparam logic [ALU_OP_W-1:0] OP_OR  = 3'b011;
  localparam logic [ALU_OP_W-1:0] OP_MUL = 3'b100;
  localparam logic [ALU_OP_W-1:0] OP_SLL = 3'b101;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef struct packed {
    logic [ALU_XLEN-1:0] operand1;
    logic [ALU_XLEN-1:0] operand2;
    logic [ALU_XLEN-1:0] branch_target;
    logic [ALU_OP_W-1:0] alu_op;
    logic [4:0]          rd;
    logic                reg_write;
    logic                is_branch;
    logic                branch_ne;
    logic                illegal;
  } dec_t;

  localparam int DEC_W = $bits(dec_t);

endpackage

// File: rtl/alu_issue_decode.sv
// alu_issue_decode -- combinational RV32 decode into the ALU issue bundle.
//   instr    : instruction word
//   rs1_val  : rs1 register value
//   rs2_val  : rs2 register value
//   pc       : instruction PC
//   dec      : decoded bundle (operands, op, rd, flags, branch target)
// Build option: ALU_ISSUE_MUL_EN enables decode of MUL (f7=0000001, f3=000);
// without it that encoding is reported illegal.
module alu_issue_decode
  import alu_pkg::*;
(
  input  logic [31:0]         instr,
  input  logic [ALU_XLEN-1:0] rs1_val,
  input  logic [ALU_XLEN-1:0] rs2_val,
  input  logic [ALU_XLEN-1:0] pc,
  output dec_t                dec
);

  logic [6:0]          opcode;
  logic [2:0]          f3;
  logic [6:0]          f7;
  logic [ALU_XLEN-1:0] imm_i, imm_s, imm_b;
  logic                legal;
  logic                unused_rs1_field;

  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  // register indices are resolved upstream; only the values arrive here
  assign unused_rs1_field = ^instr[19:15];

  always_comb begin
    dec   = '0;
    legal = 1'b0;
    case (opcode)
      OPC_OP: begin
        dec.operand1  = rs1_val;
        dec.operand2  = rs2_val;
        dec.reg_write = 1'b1;
        if (f7 == F7_BASE) begin
          legal = 1'b1;
          case (f3)
            F3_ADD:  dec.alu_op = OP_ADD;
            F3_SLL:  dec.alu_op = OP_SLL;
            F3_OR:   dec.alu_op = OP_OR;
            F3_AND:  dec.alu_op = OP_AND;
            default: legal = 1'b0;
          endcase
        end else if (f7 == F7_ALT && f3 == F3_ADD) begin
          legal      = 1'b1;
          dec.alu_op = OP_SUB;
        end
`ifdef ALU_ISSUE_MUL_EN
        else if (f7 == F7_MULDIV && f3 == F3_ADD) begin
          legal      = 1'b1;
          dec.alu_op = OP_MUL;
        end
`endif
      end
      OPC_OP_IMM: begin
        dec.operand1  = rs1_val;
        dec.operand2  = imm_i;
        dec.reg_write = 1'b1;
        legal         = 1'b1;
        case (f3)
          F3_ADD:  dec.alu_op = OP_ADD;
          F3_OR:   dec.alu_op = OP_OR;
          F3_AND:  dec.alu_op = OP_AND;
          F3_SLL: begin
            legal        = (f7 == F7_BASE);
            dec.alu_op   = OP_SLL;
            dec.operand2 = {{(ALU_XLEN-5){1'b0}}, instr[24:20]};
          end
          default: legal = 1'b0;
        endcase
      end
      OPC_LOAD: begin
        legal         = 1'b1;
        dec.operand1  = rs1_val;
        dec.operand2  = imm_i;
        dec.reg_write = 1'b1;
      end
      OPC_STORE: begin
        legal        = 1'b1;
        dec.operand1 = rs1_val;
        dec.operand2 = imm_s;
      end
      OPC_BRANCH: begin
        legal             = (f3 == F3_BEQ) || (f3 == F3_BNE);
        dec.alu_op        = OP_SUB;
        dec.operand1      = rs1_val;
        dec.operand2      = rs2_val;
        dec.is_branch     = 1'b1;
        dec.branch_ne     = (f3 == F3_BNE);
        dec.branch_target = pc + imm_b;
      end
      default: legal = 1'b0;
    endcase

    // illegal encodings collapse to an all-zero NOP with only the flag set
    if (!legal) begin
      dec         = '0;
      dec.illegal = 1'b1;
    end else if (dec.reg_write) begin
      dec.rd = instr[11:7];
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage -- ID/EX stage in front of the ALU with a 2-entry skid buffer.
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid/in_ready   : upstream handshake (in_ready is a flop output)
//   in_instr, in_rs1_val, in_rs2_val, in_pc : decoded-register-read inputs
//   flush               : drop every held entry, highest priority
//   out_valid/out_ready : EX handshake; out_* fields held while stalled
//   out_operand1/2, out_alu_op, out_rd, out_reg_write, out_is_branch,
//   out_branch_ne, out_branch_target, out_illegal : registered ALU bundle
//   alu_zero            : ALU zero flag for the entry at the output
//   branch_taken        : combinational BEQ/BNE resolution
// Build option: ALU_ISSUE_MUL_EN (MUL decode, see alu_issue_decode).
// XLEN/OP_W must match alu_pkg::ALU_XLEN/ALU_OP_W (bundle is fixed-width).
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int XLEN = ALU_XLEN,
  parameter int OP_W = ALU_OP_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_rs1_val,
  input  logic [XLEN-1:0] in_rs2_val,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_operand1,
  output logic [XLEN-1:0] out_operand2,
  output logic [OP_W-1:0] out_alu_op,
  output logic [4:0]      out_rd,
  output logic            out_reg_write,
  output logic            out_is_branch,
  output logic            out_branch_ne,
  output logic [XLEN-1:0] out_branch_target,
  output logic            out_illegal,
  input  logic            alu_zero,
  output logic            branch_taken
);

  dec_t dec, main_q, spare_q;
  logic main_v, spare_v;
  logic accept, dequeue;

  alu_issue_decode u_decode (
    .instr   (in_instr),
    .rs1_val (in_rs1_val),
    .rs2_val (in_rs2_val),
    .pc      (in_pc),
    .dec     (dec)
  );

  assign in_ready = ~spare_v;
  assign accept   = in_valid & in_ready;
  assign dequeue  = main_v & out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_v  <= 1'b0;
      spare_v <= 1'b0;
      main_q  <= '0;
      spare_q <= '0;
    end else if (flush) begin
      main_v  <= 1'b0;
      spare_v <= 1'b0;
    end else if (main_v && !dequeue) begin
      // main is stalled; an accept can only happen when spare is empty
      if (accept) begin
        spare_q <= dec;
        spare_v <= 1'b1;
      end
    end else if (spare_v) begin
      // main frees up: promote spare (no accept possible this cycle)
      main_q  <= spare_q;
      spare_v <= 1'b0;
    end else begin
      main_v <= accept;
      if (accept) main_q <= dec;
    end
  end

  assign out_valid         = main_v;
  assign out_operand1      = main_q.operand1;
  assign out_operand2      = main_q.operand2;
  assign out_alu_op        = main_q.alu_op;
  assign out_rd            = main_q.rd;
  assign out_reg_write     = main_q.reg_write;
  assign out_is_branch     = main_q.is_branch;
  assign out_branch_ne     = main_q.branch_ne;
  assign out_branch_target = main_q.branch_target;
  assign out_illegal       = main_q.illegal;
  assign branch_taken      = main_v & main_q.is_branch & (alu_zero ^ main_q.branch_ne);

endmodule

// File: tb/tb_alu_issue_stage.sv
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr, in_rs1_val, in_rs2_val, in_pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_operand1, out_operand2, out_branch_target;
  logic [2:0]  out_alu_op;
  logic [4:0]  out_rd;
  logic        out_reg_write, out_is_branch, out_branch_ne, out_illegal;
  logic        alu_zero;
  logic        branch_taken;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_issue_stage dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_instr          (in_instr),
    .in_rs1_val        (in_rs1_val),
    .in_rs2_val        (in_rs2_val),
    .in_pc             (in_pc),
    .flush             (flush),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_operand1      (out_operand1),
    .out_operand2      (out_operand2),
    .out_alu_op        (out_alu_op),
    .out_rd            (out_rd),
    .out_reg_write     (out_reg_write),
    .out_is_branch     (out_is_branch),
    .out_branch_ne     (out_branch_ne),
    .out_branch_target (out_branch_target),
    .out_illegal       (out_illegal),
    .alu_zero          (alu_zero),
    .branch_taken      (branch_taken)
  );

  typedef struct {
    logic [31:0] op1, op2, tgt;
    logic [2:0]  op;
    logic [4:0]  rd;
    bit          rw, br, ne, ill;
  } exp_t;

  // expected contents of the stage, oldest first (capacity 2)
  exp_t q[$];

  function automatic exp_t ref_decode(logic [31:0] ins, logic [31:0] r1, logic [31:0] r2,
                                      logic [31:0] p);
    exp_t e;
    bit ok;
    int imm_i, imm_s, imm_b;
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic signed [11:0] i12, s12;
    logic signed [12:0] b13;
    opc = ins[6:0];
    f3  = ins[14:12];
    f7  = ins[31:25];
    i12 = ins[31:20];
    s12 = {ins[31:25], ins[11:7]};
    b13 = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    imm_i = i12;
    imm_s = s12;
    imm_b = b13;
    e  = '{default: 0};
    ok = 0;
    if (opc == 7'h33) begin
      e.op1 = r1; e.op2 = r2; e.rw = 1;
      if (f7 == 0 && f3 == 0)      begin ok = 1; e.op = 0; end
      else if (f7 == 0 && f3 == 1) begin ok = 1; e.op = 5; end
      else if (f7 == 0 && f3 == 6) begin ok = 1; e.op = 3; end
      else if (f7 == 0 && f3 == 7) begin ok = 1; e.op = 2; end
      else if (f7 == 7'h20 && f3 == 0) begin ok = 1; e.op = 1; end
`ifdef ALU_ISSUE_MUL_EN
      else if (f7 == 1 && f3 == 0) begin ok = 1; e.op = 4; end
`endif
    end else if (opc == 7'h13) begin
      e.op1 = r1; e.op2 = imm_i; e.rw = 1;
      if (f3 == 0)      begin ok = 1; e.op = 0; end
      else if (f3 == 6) begin ok = 1; e.op = 3; end
      else if (f3 == 7) begin ok = 1; e.op = 2; end
      else if (f3 == 1 && f7 == 0) begin ok = 1; e.op = 5; e.op2 = ins[24:20] % 32; end
    end else if (opc == 7'h03) begin
      ok = 1; e.op = 0; e.op1 = r1; e.op2 = imm_i; e.rw = 1;
    end else if (opc == 7'h23) begin
      ok = 1; e.op = 0; e.op1 = r1; e.op2 = imm_s;
    end else if (opc == 7'h63 && f3 < 2) begin
      ok = 1; e.op = 1; e.op1 = r1; e.op2 = r2; e.br = 1; e.ne = (f3 == 1);
      e.tgt = p + imm_b;
    end
    if (!ok) begin
      e = '{default: 0};
      e.ill = 1;
    end else if (e.rw) begin
      e.rd = ins[11:7];
    end
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    int k;
    r = $urandom;
    k = $urandom_range(0, 9);
    case (k)
      0, 1: begin
        r[6:0] = 7'h33;
        case ($urandom_range(0, 3))
          0, 1: r[31:25] = 7'h00;
          2:    r[31:25] = 7'h20;
          default: r[31:25] = 7'h01;
        endcase
        if ($urandom_range(0, 1) == 1) r[14:12] = 3'b000;
      end
      2, 3: begin
        r[6:0] = 7'h13;
        if ($urandom_range(0, 2) == 0) begin r[14:12] = 3'b001; r[31:25] = 7'h00; end
      end
      4: r[6:0] = 7'h03;
      5: r[6:0] = 7'h23;
      6, 7: begin
        r[6:0] = 7'h63;
        if ($urandom_range(0, 3) != 0) r[14:13] = 2'b00;
      end
      8: ;
      default: r[6:0] = 7'h7F;
    endcase
    return r;
  endfunction

  task automatic step(input bit v, input logic [31:0] ins, input logic [31:0] r1,
                      input logic [31:0] r2, input logic [31:0] p,
                      input bit ordy, input bit fl, input bit az);
    exp_t e;
    bit ev, bt;
    int pre;
    logic [107:0] got, want;
    in_valid = v; in_instr = ins; in_rs1_val = r1; in_rs2_val = r2; in_pc = p;
    out_ready = ordy; flush = fl; alu_zero = az;
    #1;
    e  = '{default: 0};
    ev = (q.size() != 0);
    if (ev) e = q[0];
    tests++;
    if (out_valid !== ev) begin
      fails++; $display("FAIL out_valid got %0b exp %0b", out_valid, ev);
    end
    tests++;
    if (in_ready !== (q.size() < 2)) begin
      fails++; $display("FAIL in_ready got %0b exp %0b", in_ready, q.size() < 2);
    end
    if (ev) begin
      got  = {out_operand1, out_operand2, out_branch_target, out_alu_op, out_rd,
              out_reg_write, out_is_branch, out_branch_ne, out_illegal};
      want = {e.op1, e.op2, e.tgt, e.op, e.rd, e.rw, e.br, e.ne, e.ill};
      tests++;
      if (got !== want) begin
        fails++; $display("FAIL out_bundle got %h exp %h", got, want);
      end
    end
    bt = ev && e.br && (az ^ e.ne);
    tests++;
    if (branch_taken !== bt) begin
      fails++; $display("FAIL branch_taken got %0b exp %0b", branch_taken, bt);
    end
    @(posedge clk);
    pre = q.size();
    if (fl) q.delete();
    else begin
      if (pre > 0 && ordy) void'(q.pop_front());
      if (v && pre < 2) q.push_back(ref_decode(ins, r1, r2, p));
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 32'h0, 0, 0, 0, 1, 0, 0);
  endtask

  task automatic check_cleared(input string name);
    alu_zero = 1'b1;
    #1;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || branch_taken !== 1'b0 ||
        {out_operand1, out_operand2, out_branch_target, out_alu_op, out_rd,
         out_reg_write, out_is_branch, out_branch_ne, out_illegal} !== 108'h0) begin
      fails++;
      $display("FAIL %s got v=%0b rdy=%0b bt=%0b op1=%h op2=%h ill=%0b exp all-zero, rdy=1",
               name, out_valid, in_ready, branch_taken, out_operand1, out_operand2, out_illegal);
    end
  endtask

  task automatic test_reset();
    rst_n = 0; in_valid = 1; in_instr = 32'h002081B3; in_rs1_val = 1; in_rs2_val = 2;
    in_pc = 0; flush = 0; out_ready = 1; alu_zero = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    q.delete();
    check_cleared("reset_state");
  endtask

  task automatic test_add();
    step(1, {7'h00, 5'd2, 5'd1, 3'b000, 5'd3, 7'h33}, 5, 7, 0, 1, 0, 0);
    tests++;
    if (out_valid !== 1 || out_alu_op !== 3'b000 || out_operand1 !== 5 ||
        out_operand2 !== 7 || out_rd !== 3 || out_reg_write !== 1) begin
      fails++;
      $display("FAIL add got v=%0b op=%0d a=%0d b=%0d rd=%0d rw=%0b exp 1 0 5 7 3 1",
               out_valid, out_alu_op, out_operand1, out_operand2, out_rd, out_reg_write);
    end
    idle(1);
  endtask

  task automatic test_imm();
    step(1, {12'hFFF, 5'd1, 3'b000, 5'd4, 7'h13}, 32'h1234, 0, 0, 1, 0, 0);
    tests++;
    if (out_alu_op !== 3'b000 || out_operand2 !== 32'hFFFF_FFFF || out_operand1 !== 32'h1234) begin
      fails++;
      $display("FAIL addi got op=%0d b=%h exp op=0 b=ffffffff", out_alu_op, out_operand2);
    end
    step(1, {7'h00, 5'd3, 5'd1, 3'b001, 5'd4, 7'h13}, 32'h1234, 0, 0, 1, 0, 0);
    tests++;
    if (out_alu_op !== 3'b101 || out_operand2 !== 32'd3 || out_rd !== 4) begin
      fails++;
      $display("FAIL slli got op=%0d b=%h rd=%0d exp op=5 b=3 rd=4", out_alu_op, out_operand2, out_rd);
    end
    idle(1);
  endtask

  task automatic test_branch();
    // beq x1,x2,+16 then bne with the same offset, pc = 0x100
    step(1, {1'b0, 6'd0, 5'd2, 5'd1, 3'b000, 4'b1000, 1'b0, 7'h63}, 9, 9, 32'h100, 1, 0, 0);
    alu_zero = 1; #1;
    tests++;
    if (out_alu_op !== 3'b001 || out_branch_target !== 32'h110 || out_is_branch !== 1 ||
        out_reg_write !== 0 || branch_taken !== 1) begin
      fails++;
      $display("FAIL beq got op=%0d tgt=%h br=%0b taken=%0b exp op=1 tgt=110 br=1 taken=1",
               out_alu_op, out_branch_target, out_is_branch, branch_taken);
    end
    step(1, {1'b0, 6'd0, 5'd2, 5'd1, 3'b001, 4'b1000, 1'b0, 7'h63}, 9, 9, 32'h100, 1, 0, 1);
    alu_zero = 1; #1;
    tests++;
    if (out_branch_ne !== 1 || out_branch_target !== 32'h110 || branch_taken !== 0) begin
      fails++;
      $display("FAIL bne got ne=%0b tgt=%h taken=%0b exp ne=1 tgt=110 taken=0",
               out_branch_ne, out_branch_target, branch_taken);
    end
    idle(1);
  endtask

  task automatic test_back_to_back();
    step(1, {12'd1, 5'd1, 3'b000, 5'd10, 7'h13}, 0, 0, 0, 0, 0, 0);
    step(1, {12'd2, 5'd1, 3'b000, 5'd11, 7'h13}, 0, 0, 0, 0, 0, 0);
    tests++;
    if (in_ready !== 0 || out_valid !== 1 || out_rd !== 10) begin
      fails++;
      $display("FAIL skid_full got rdy=%0b v=%0b rd=%0d exp rdy=0 v=1 rd=10", in_ready, out_valid, out_rd);
    end
    step(1, {12'd3, 5'd1, 3'b000, 5'd12, 7'h13}, 0, 0, 0, 0, 0, 0);
    step(0, 32'h0, 0, 0, 0, 1, 0, 0);
    tests++;
    if (out_valid !== 1 || out_rd !== 11 || out_operand2 !== 2 || in_ready !== 1) begin
      fails++;
      $display("FAIL drain_order got v=%0b rd=%0d b=%0d rdy=%0b exp 1 11 2 1",
               out_valid, out_rd, out_operand2, in_ready);
    end
    step(0, 32'h0, 0, 0, 0, 1, 0, 0);
    tests++;
    if (out_valid !== 0) begin
      fails++; $display("FAIL drain_empty got v=%0b exp 0", out_valid);
    end
  endtask

  task automatic test_flush();
    step(1, {12'd5, 5'd1, 3'b000, 5'd20, 7'h13}, 0, 0, 0, 0, 0, 0);
    step(1, {12'd6, 5'd1, 3'b000, 5'd21, 7'h13}, 0, 0, 0, 0, 0, 0);
    step(1, {12'd7, 5'd1, 3'b000, 5'd22, 7'h13}, 0, 0, 0, 1, 1, 0);
    tests++;
    if (out_valid !== 0 || in_ready !== 1) begin
      fails++; $display("FAIL flush got v=%0b rdy=%0b exp v=0 rdy=1", out_valid, in_ready);
    end
    idle(2);
    // an accept in the flush cycle with an empty stage must also vanish
    step(1, {12'd8, 5'd1, 3'b000, 5'd23, 7'h13}, 0, 0, 0, 1, 1, 0);
    tests++;
    if (out_valid !== 0) begin
      fails++; $display("FAIL flush_accept got v=%0b exp 0", out_valid);
    end
  endtask

  task automatic test_mul_illegal();
    bit exp_ill;
    logic [2:0] exp_op;
`ifdef ALU_ISSUE_MUL_EN
    exp_ill = 0; exp_op = 3'b100;
`else
    exp_ill = 1; exp_op = 3'b000;
`endif
    step(1, 32'h0220_81B3, 6, 7, 0, 1, 0, 0);
    tests++;
    if (out_illegal !== exp_ill || out_alu_op !== exp_op || out_reg_write !== !exp_ill) begin
      fails++;
      $display("FAIL mul got ill=%0b op=%0d rw=%0b exp ill=%0b op=%0d", out_illegal, out_alu_op,
               out_reg_write, exp_ill, exp_op);
    end
    step(1, 32'h0000_007F, 6, 7, 0, 1, 0, 0);
    tests++;
    if (out_illegal !== 1 || out_reg_write !== 0 || out_operand1 !== 0 || out_valid !== 1) begin
      fails++;
      $display("FAIL illegal got ill=%0b rw=%0b a=%h v=%0b exp ill=1 rw=0 a=0 v=1",
               out_illegal, out_reg_write, out_operand1, out_valid);
    end
    idle(1);
  endtask

  task automatic test_reset_midstream();
    step(1, 32'h0020_81B3, 3, 4, 0, 0, 0, 0);
    step(1, 32'h0030_81B3, 3, 4, 0, 0, 0, 0);
    rst_n = 0; in_valid = 1;
    @(posedge clk);
    q.delete();
    @(negedge clk);
    rst_n = 1;
    check_cleared("reset_midstream");
  endtask

  task automatic test_random();
    for (int i = 0; i < 2000; i++)
      step($urandom_range(0, 9) < 7, rand_instr(), $urandom, $urandom, $urandom,
           $urandom_range(0, 9) < 6, $urandom_range(0, 49) == 0, $urandom_range(0, 1) == 1);
    idle(3);
  endtask

  initial begin
    test_reset();
    test_add();
    test_imm();
    test_branch();
    test_back_to_back();
    test_flush();
    test_mul_illegal();
    test_reset_midstream();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
